// File: rtl/exc_arbiter.sv
// Exception arbitration between MEM and CP0: synchronises interrupts, prioritises per-instruction
// exceptions, drives CP0 exception inputs, and issues a registered flush/redirect followed by a drain window.
module exc_arbiter #(
   parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
   parameter int          DRAIN_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        valid_i,
   input  logic        stall_i,
   input  logic [31:0] pc_i,
   input  logic        is_branch_i,
   input  logic [7:0]  exc_flags_i,
   input  logic        eret_i,
   input  logic [5:0]  hw_int_i,
   input  logic        time_int_i,
   input  logic [31:0] status_i,
   input  logic [31:0] cause_i,
   input  logic [31:0] epc_i,
   output logic [7:0]  int_o,
   output logic [31:0] excepttype_o,
   output logic        except_handle_o,
   output logic [31:0] current_inst_addr_o,
   output logic        is_in_delay_slot_o,
   output logic        flush_o,
   output logic [31:0] new_pc_o
);

   // Exception codes; interrupts occupy encode_Int0 + IP index.
   localparam logic [31:0] encode_None    = 32'h0000_0000;
   localparam logic [31:0] encode_AdEL_if = 32'h0000_0004;
   localparam logic [31:0] encode_AdES    = 32'h0000_0005;
   localparam logic [31:0] encode_Sys     = 32'h0000_0008;
   localparam logic [31:0] encode_Bp      = 32'h0000_0009;
   localparam logic [31:0] encode_Ri      = 32'h0000_000A;
   localparam logic [31:0] encode_Ov      = 32'h0000_000C;
   localparam logic [31:0] encode_Tr      = 32'h0000_000D;
   localparam logic [31:0] encode_eret    = 32'h0000_000E;
   localparam logic [31:0] encode_Int0    = 32'h0000_0010;
   localparam logic [31:0] encode_AdEL_ld = 32'h0000_0024;

   localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FLUSH,
      ST_DRAIN
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [3:0]  r_cnt;
   logic [3:0]  w_cnt_nxt;
   logic [5:0]  r_hw_s1;
   logic [5:0]  r_hw_s2;
   logic        r_flush;
   logic        r_ds;
   logic [31:0] r_new_pc;

   logic [7:0]  w_ip;
   logic        w_int_pend;
   logic        w_cand;
   logic        w_has_event;
   logic        w_sel_eret;
   logic [31:0] w_code;
   logic        w_accept;
   logic        w_unused;

   assign w_unused = &{1'b0, status_i[31:16], status_i[7:2], cause_i[31:10], cause_i[7:0]};

   assign int_o      = {r_hw_s2[5] | time_int_i, r_hw_s2[4:0], cause_i[9:8]};
   assign w_ip       = int_o & status_i[15:8];
   assign w_int_pend = status_i[0] & ~status_i[1] & (|w_ip);
   assign w_cand     = valid_i & ~stall_i & (r_state == ST_IDLE);

   // Priority select: interrupts first, then flags in bit order, then eret.
   always_comb begin
      w_has_event = 1'b1;
      w_sel_eret  = 1'b0;
      w_code      = encode_None;
      if (w_int_pend) begin
         for (int i = 7; i >= 0; i--) begin
            if (w_ip[i]) begin
               w_code = encode_Int0 + 32'(i);
            end
         end
      end else if (exc_flags_i[0]) begin
         w_code = encode_AdEL_if;
      end else if (exc_flags_i[1]) begin
         w_code = encode_Ri;
      end else if (exc_flags_i[2]) begin
         w_code = encode_Ov;
      end else if (exc_flags_i[3]) begin
         w_code = encode_Tr;
      end else if (exc_flags_i[4]) begin
         w_code = encode_Sys;
      end else if (exc_flags_i[5]) begin
         w_code = encode_Bp;
      end else if (exc_flags_i[6]) begin
         w_code = encode_AdEL_ld;
      end else if (exc_flags_i[7]) begin
         w_code = encode_AdES;
      end else if (eret_i) begin
         w_code     = encode_eret;
         w_sel_eret = 1'b1;
      end else begin
         w_has_event = 1'b0;
      end
   end

   assign w_accept            = w_cand & w_has_event;
   assign except_handle_o     = w_accept;
   assign excepttype_o        = w_accept ? w_code : encode_None;
   assign current_inst_addr_o = pc_i;
   assign is_in_delay_slot_o  = r_ds;
   assign flush_o             = r_flush;
   assign new_pc_o            = r_new_pc;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_state_nxt = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            w_cnt_nxt   = DRAIN_LOAD;
            w_state_nxt = (DRAIN_CYCLES > 1) ? ST_DRAIN : ST_IDLE;
         end
         ST_DRAIN: begin
            if (r_cnt == 4'd0) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_cnt    <= 4'd0;
         r_hw_s1  <= 6'd0;
         r_hw_s2  <= 6'd0;
         r_flush  <= 1'b0;
         r_ds     <= 1'b0;
         r_new_pc <= 32'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_hw_s1 <= hw_int_i;
         r_hw_s2 <= r_hw_s1;
         r_flush <= w_accept;
         if (w_accept) begin
            r_new_pc <= w_sel_eret ? epc_i : EXC_VECTOR;
         end
         // The instruction after a committed branch is its delay slot; flushes break that link.
         if (w_accept || r_flush) begin
            r_ds <= 1'b0;
         end else if (valid_i && !stall_i) begin
            r_ds <= is_branch_i;
         end
      end
   end

endmodule

// File: tb/tb_exc_arbiter.sv
// Self-checking bench for exc_arbiter: directed scenarios then random traffic, all compared
// each cycle against a cycle-level behavioural model of the arbitration rules.
module tb_exc_arbiter;

   localparam logic [31:0] EXC = 32'hBFC00380;
   localparam int          D   = 2;

   localparam logic [31:0] C_NONE    = 32'h00;
   localparam logic [31:0] C_ADEL_IF = 32'h04;
   localparam logic [31:0] C_ADES    = 32'h05;
   localparam logic [31:0] C_SYS     = 32'h08;
   localparam logic [31:0] C_BP      = 32'h09;
   localparam logic [31:0] C_RI      = 32'h0A;
   localparam logic [31:0] C_OV      = 32'h0C;
   localparam logic [31:0] C_TR      = 32'h0D;
   localparam logic [31:0] C_ERET    = 32'h0E;
   localparam logic [31:0] C_INT0    = 32'h10;
   localparam logic [31:0] C_ADEL_LD = 32'h24;
   localparam logic [31:0] FLAG_CODE [8] = '{C_ADEL_IF, C_RI, C_OV, C_TR, C_SYS, C_BP, C_ADEL_LD, C_ADES};

   logic        clk;
   logic        reset;
   logic        valid_i, stall_i, is_branch_i, eret_i, time_int_i;
   logic [31:0] pc_i, status_i, cause_i, epc_i;
   logic [7:0]  exc_flags_i;
   logic [5:0]  hw_int_i;
   logic [7:0]  int_o;
   logic [31:0] excepttype_o, current_inst_addr_o, new_pc_o;
   logic        except_handle_o, is_in_delay_slot_o, flush_o;

   int n_checks;
   int n_errors;

   // Behavioural model state
   logic [5:0]  m_hw[$];
   int          m_block;
   bit          m_flush;
   bit          m_ds;
   logic [31:0] m_newpc;

   exc_arbiter #(.EXC_VECTOR(EXC), .DRAIN_CYCLES(D)) dut (
      .clk(clk), .reset(reset), .valid_i(valid_i), .stall_i(stall_i), .pc_i(pc_i),
      .is_branch_i(is_branch_i), .exc_flags_i(exc_flags_i), .eret_i(eret_i),
      .hw_int_i(hw_int_i), .time_int_i(time_int_i), .status_i(status_i),
      .cause_i(cause_i), .epc_i(epc_i), .int_o(int_o), .excepttype_o(excepttype_o),
      .except_handle_o(except_handle_o), .current_inst_addr_o(current_inst_addr_o),
      .is_in_delay_slot_o(is_in_delay_slot_o), .flush_o(flush_o), .new_pc_o(new_pc_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // Returns {event, code} for the current inputs given the visible interrupt vector.
   function automatic logic [32:0] model_event(input logic [7:0] ints);
      logic [7:0] ip;
      ip = ints & status_i[15:8];
      if (status_i[0] && !status_i[1] && ip != 8'd0) begin
         for (int i = 0; i < 8; i++) begin
            if (ip[i]) return {1'b1, C_INT0 + 32'(i)};
         end
      end
      for (int i = 0; i < 8; i++) begin
         if (exc_flags_i[i]) return {1'b1, FLAG_CODE[i]};
      end
      if (eret_i) return {1'b1, C_ERET};
      return {1'b0, C_NONE};
   endfunction

   task automatic set_idle();
      valid_i     = 1'b0;
      stall_i     = 1'b0;
      exc_flags_i = 8'd0;
      eret_i      = 1'b0;
      is_branch_i = 1'b0;
   endtask

   // Check every output against the model, then advance one clock and update the model.
   task automatic tick(input string tag);
      logic [7:0]  exp_int;
      logic [32:0] ev;
      bit          acc;
      #3;
      exp_int = {m_hw[1][5] | time_int_i, m_hw[1][4:0], cause_i[9:8]};
      ev      = model_event(exp_int);
      acc     = valid_i && !stall_i && (m_block == 0) && ev[32];
      chk({tag, ".int_o"}, 32'(int_o), 32'(exp_int));
      chk({tag, ".handle"}, 32'(except_handle_o), 32'(acc));
      chk({tag, ".type"}, excepttype_o, acc ? ev[31:0] : C_NONE);
      chk({tag, ".addr"}, current_inst_addr_o, pc_i);
      chk({tag, ".ds"}, 32'(is_in_delay_slot_o), 32'(m_ds));
      chk({tag, ".flush"}, 32'(flush_o), 32'(m_flush));
      if (m_flush) chk({tag, ".new_pc"}, new_pc_o, m_newpc);
      @(posedge clk);
      if (reset) begin
         m_hw    = '{6'd0, 6'd0};
         m_block = 0;
         m_flush = 1'b0;
         m_ds    = 1'b0;
         m_newpc = 32'd0;
      end else begin
         if (acc || m_flush) m_ds = 1'b0;
         else if (valid_i && !stall_i) m_ds = is_branch_i;
         m_flush = acc;
         if (acc) begin
            m_newpc = (ev[31:0] == C_ERET) ? epc_i : EXC;
            m_block = (D > 1) ? D + 1 : 1;
         end else if (m_block > 0) begin
            m_block--;
         end
         m_hw.push_front(hw_int_i);
         void'(m_hw.pop_back());
      end
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      m_hw     = '{6'd0, 6'd0};
      m_block  = 0;
      m_flush  = 1'b0;
      m_ds     = 1'b0;
      m_newpc  = 32'd0;
      reset    = 1'b1;
      set_idle();
      pc_i       = 32'd0;
      hw_int_i   = 6'd0;
      time_int_i = 1'b0;
      status_i   = 32'h0000FF01;
      cause_i    = 32'd0;
      epc_i      = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.flush", 32'(flush_o), 32'd0);
      chk("rst.new_pc", new_pc_o, 32'd0);
      chk("rst.handle", 32'(except_handle_o), 32'd0);
      chk("rst.type", excepttype_o, C_NONE);
      chk("rst.ds", 32'(is_in_delay_slot_o), 32'd0);
      chk("rst.int_o", 32'(int_o), 32'd0);
      tick("rst");
      reset = 1'b0;
      tick("idle");

      // Sys, then Ri held through the flush and drain window
      valid_i = 1'b1; pc_i = 32'h80001000; exc_flags_i = 8'h10;
      #2; chk("sys.handle", 32'(except_handle_o), 32'd1); chk("sys.type", excepttype_o, C_SYS);
      tick("sys");
      exc_flags_i = 8'h02; pc_i = 32'h80001004;
      #2; chk("sys.flush", 32'(flush_o), 32'd1); chk("sys.new_pc", new_pc_o, EXC);
      chk("flushcyc.handle", 32'(except_handle_o), 32'd0);
      tick("flushcyc");
      repeat (2) begin
         #2; chk("drain.ri_ignored", 32'(except_handle_o), 32'd0);
         tick("drain");
      end
      #2; chk("ri_after_drain.type", excepttype_o, C_RI);
      tick("ri_acc");
      set_idle();
      repeat (4) tick("settle1");

      // Branch commits, then Ov in its delay slot
      valid_i = 1'b1; is_branch_i = 1'b1; pc_i = 32'h80000100;
      tick("branch");
      is_branch_i = 1'b0; exc_flags_i = 8'h04; pc_i = 32'h80000104;
      #2; chk("dslot.ds", 32'(is_in_delay_slot_o), 32'd1); chk("dslot.type", excepttype_o, C_OV);
      chk("dslot.addr", current_inst_addr_o, 32'h80000104);
      tick("dslot");
      set_idle();
      #2; chk("dslot.ds_cleared", 32'(is_in_delay_slot_o), 32'd0);
      repeat (4) tick("settle2");

      // Hardware interrupt line 2 -> IP4, masked by EXL, then taken
      hw_int_i = 6'b000100;
      tick("hw_sync1");
      #2; chk("hw.int_o4_not_yet", 32'(int_o[4]), 32'd0);
      tick("hw_sync2");
      #2; chk("hw.int_o4", 32'(int_o[4]), 32'd1);
      status_i = 32'h0000FF03; valid_i = 1'b1; pc_i = 32'h80000200;
      repeat (2) begin
         #2; chk("exl.no_accept", 32'(except_handle_o), 32'd0);
         tick("exl");
      end
      status_i = 32'h0000FF01;
      #2; chk("int4.type", excepttype_o, C_INT0 + 32'd4);
      tick("int4");
      hw_int_i = 6'd0;
      set_idle();
      repeat (5) tick("settle3");

      // Ri + AdES under stall
      valid_i = 1'b1; stall_i = 1'b1; exc_flags_i = 8'h82; pc_i = 32'h80000300;
      repeat (3) begin
         #2; chk("stall.no_handle", 32'(except_handle_o), 32'd0);
         tick("stall");
      end
      stall_i = 1'b0;
      #2; chk("stall_rel.type", excepttype_o, C_RI);
      tick("stall_rel");
      set_idle();
      repeat (4) tick("settle4");

      // eret redirects to EPC
      valid_i = 1'b1; eret_i = 1'b1; epc_i = 32'h80002000; pc_i = 32'h80000400;
      #2; chk("eret.type", excepttype_o, C_ERET);
      tick("eret");
      set_idle(); epc_i = 32'd0;
      #2; chk("eret.flush", 32'(flush_o), 32'd1); chk("eret.new_pc", new_pc_o, 32'h80002000);
      tick("eret_f");
      repeat (4) tick("settle5");

      // Reset while draining, then an immediate Bp
      valid_i = 1'b1; exc_flags_i = 8'h10; pc_i = 32'h80000500;
      tick("pre_drain");
      set_idle();
      tick("pre_drain_f");
      reset = 1'b1;
      tick("rst_drain");
      reset = 1'b0;
      valid_i = 1'b1; exc_flags_i = 8'h20; pc_i = 32'h80000600;
      #2; chk("rst_drain.flush", 32'(flush_o), 32'd0);
      chk("bp.handle", 32'(except_handle_o), 32'd1); chk("bp.type", excepttype_o, C_BP);
      tick("bp");
      set_idle();
      repeat (4) tick("settle6");

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         reset       = ($urandom_range(0, 60) == 0);
         valid_i     = ($urandom_range(0, 3) != 0);
         stall_i     = ($urandom_range(0, 3) == 0);
         is_branch_i = ($urandom_range(0, 3) == 0);
         exc_flags_i = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'd0;
         eret_i      = ($urandom_range(0, 7) == 0);
         time_int_i  = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 7) == 0) hw_int_i = 6'($urandom);
         case ($urandom_range(0, 3))
            0: status_i = 32'h0000FF01;
            1: status_i = 32'h0000FF03;
            2: status_i = 32'h00000401;
            default: status_i = $urandom;
         endcase
         cause_i = $urandom & 32'h00000300;
         epc_i   = $urandom;
         pc_i    = $urandom;
         tick("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
